// File: rtl/decoder_input_framer_if.sv
// ---------------------------------------------------------------------------
// decoder_input_framer_if
//   Bundles the serial input, the decoded-word handshake and the error flags
//   of decoder_input_framer.
//
//   sdi, sdi_en   serial data and its bit strobe (towards the framer)
//   code          7-bit decoded word (from the framer)
//   code_valid    code holds an unconsumed word (from the framer)
//   code_ready    downstream accepts code (towards the framer)
//   frame_err     sticky bad-stop / parity / timeout flag (from the framer)
//   overrun       sticky dropped-word flag (from the framer)
//   clear_err     synchronous clear of both sticky flags (towards the framer)
//
//   modport slave  : the framer itself
//   modport master : the block that feeds bits and consumes words
// ---------------------------------------------------------------------------
interface decoder_input_framer_if;
   logic       sdi;
   logic       sdi_en;
   logic [6:0] code;
   logic       code_valid;
   logic       code_ready;
   logic       frame_err;
   logic       overrun;
   logic       clear_err;

   modport slave (
      input  sdi,
      input  sdi_en,
      input  code_ready,
      input  clear_err,
      output code,
      output code_valid,
      output frame_err,
      output overrun
   );

   modport master (
      output sdi,
      output sdi_en,
      output code_ready,
      output clear_err,
      input  code,
      input  code_valid,
      input  frame_err,
      input  overrun
   );
endinterface

// File: rtl/decoder_input_framer.sv
// ---------------------------------------------------------------------------
// decoder_input_framer
//   Receives strobed serial frames (start 0, 7 data bits LSB first, optional
//   even-parity bit, stop 1) and presents each good word through a one-entry
//   valid/ready output slot. Bad stop bits, parity failures and inter-strobe
//   timeouts raise the sticky frame_err; words arriving while the slot is
//   full and not being accepted are dropped and raise the sticky overrun.
//
//   Parameter TIMEOUT_CYCLES : idle clocks tolerated between strobes in a
//                              frame; the TIMEOUT_CYCLES-th consecutive idle
//                              clock aborts the frame.
//   Macro DECODER_FRAMER_PARITY_EN : when defined, a parity strobe follows
//                              the data bits (10-strobe frame); otherwise the
//                              frame is 9 strobes and has no parity check.
//
//   Ports
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : decoder_input_framer_if.slave (serial in, word out, flags)
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for a strobe with sdi=0 (start bit)
//   DATA   | shifting data bits 0..6, one per strobe
//   PARITY | sampling the even-parity bit (parity builds only)
//   STOP   | sampling the stop bit; deliver or flag, then back to IDLE
// ---------------------------------------------------------------------------
module decoder_input_framer #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   decoder_input_framer_if.slave bus
);

   localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

`ifdef DECODER_FRAMER_PARITY_EN
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_STOP   = 2'd3
   } state_t;
`endif

   state_t          state_q, state_d;
   logic [6:0]      shreg_q, shreg_d;
   logic [2:0]      bcnt_q,  bcnt_d;
   logic [TW-1:0]   tmo_q,   tmo_d;
   logic [6:0]      code_q,  code_d;
   logic            code_valid_q, code_valid_d;
   logic            frame_err_q,  frame_err_d;
   logic            overrun_q,    overrun_d;

   logic            deliver;
   logic            ferr_set;
   logic            ovr_set;
   logic            par_good;

`ifdef DECODER_FRAMER_PARITY_EN
   logic            par_ok_q, par_ok_d;
   assign par_good = par_ok_q;
`else
   assign par_good = 1'b1;
`endif

   // -----------------------------------------------------------------------
   // State register
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         shreg_q      <= '0;
         bcnt_q       <= '0;
         tmo_q        <= '0;
         code_q       <= '0;
         code_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef DECODER_FRAMER_PARITY_EN
         par_ok_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         bcnt_q       <= bcnt_d;
         tmo_q        <= tmo_d;
         code_q       <= code_d;
         code_valid_q <= code_valid_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
`ifdef DECODER_FRAMER_PARITY_EN
         par_ok_q     <= par_ok_d;
`endif
      end
   end

   // -----------------------------------------------------------------------
   // Frame FSM: next state, shift register, bit counter, timeout
   // -----------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bcnt_d   = bcnt_q;
      tmo_d    = tmo_q;
      deliver  = 1'b0;
      ferr_set = 1'b0;
`ifdef DECODER_FRAMER_PARITY_EN
      par_ok_d = par_ok_q;
`endif

      if ((state_q != S_IDLE) && !bus.sdi_en) begin
         // Idle clock inside a frame: abort on the TIMEOUT_CYCLES-th one.
         if (tmo_q == TMO_LAST) begin
            state_d  = S_IDLE;
            bcnt_d   = '0;
            tmo_d    = '0;
            ferr_set = 1'b1;
         end else if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + TW'(1);
         end
      end else begin
         // Either IDLE or a strobe inside a frame; both restart the timer.
         tmo_d = '0;
         unique case (state_q)
            S_IDLE: begin
               if (bus.sdi_en && !bus.sdi) begin
                  state_d = S_DATA;
                  bcnt_d  = '0;
               end
            end
            S_DATA: begin
               shreg_d = {bus.sdi, shreg_q[6:1]};
               if (bcnt_q == 3'd6) begin
                  bcnt_d  = '0;
`ifdef DECODER_FRAMER_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bcnt_d = bcnt_q + 3'd1;
               end
            end
`ifdef DECODER_FRAMER_PARITY_EN
            S_PARITY: begin
               // Even parity: data bits plus parity bit must XOR to zero.
               par_ok_d = ((^shreg_q) == bus.sdi);
               state_d  = S_STOP;
            end
`endif
            S_STOP: begin
               if (bus.sdi && par_good) begin
                  deliver = 1'b1;
               end else begin
                  ferr_set = 1'b1;
               end
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
               bcnt_d  = '0;
            end
         endcase
      end
   end

   // -----------------------------------------------------------------------
   // One-entry output slot and sticky flags
   // -----------------------------------------------------------------------
   always_comb begin
      code_d       = code_q;
      code_valid_d = code_valid_q;
      ovr_set      = 1'b0;

      if (deliver) begin
         // A full slot that is not draining this cycle keeps its word.
         if (code_valid_q && !bus.code_ready) begin
            ovr_set = 1'b1;
         end else begin
            code_d       = shreg_q;
            code_valid_d = 1'b1;
         end
      end else if (code_valid_q && bus.code_ready) begin
         code_valid_d = 1'b0;
      end

      // A new error event wins over a simultaneous clear.
      frame_err_d = ferr_set | (frame_err_q & ~bus.clear_err);
      overrun_d   = ovr_set  | (overrun_q   & ~bus.clear_err);
   end

   assign bus.code       = code_q;
   assign bus.code_valid = code_valid_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.overrun    = overrun_q;

endmodule
